multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 166 ++++++++++++++++
 tb/tb_multicycle_control.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle processor control FSM with memory wait states and illegal-opcode trap
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t r_state;
    state_t w_next;
    logic   r_illegal;

    // The sticky flag rises on the same edge that enters TRAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;

        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase

        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYP:      w_next = S_EXECR;
                    OP_ITYP:      w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                w_next   = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = zero;
                w_next  = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Reset must suppress every side-effecting strobe within the same cycle.
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    assign illegal = r_illegal;
    assign state   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic       illegal;
    logic [3:0] state;

    multicycle_control dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .AdrSrc    (AdrSrc),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
    localparam int EXECR = 6, ALUWB = 7, EXECI = 8, JAL = 9, BEQ = 10, TRAP = 11;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    int n_checks = 0;
    int n_errors = 0;
    int q_st[$];
    int q_mr[$];
    int memwrite_cycles;

    wire [15:0] w_out = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                         ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_out(input int st, input logic [6:0] o, input logic z,
                                            input logic mr, input logic ill);
        logic pcw, irw, rw, mw, adr;
        logic [1:0] rs, asa, asb, aop, imm;
        {pcw, irw, rw, mw, adr} = 5'b0;
        {rs, asa, asb, aop} = 8'b0;
        imm = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
        case (st)
            FETCH:    begin asb = 2; rs = 2; irw = mr; pcw = mr; end
            DECODE:   begin asa = 1; asb = 1; end
            MEMADR:   begin asa = 2; asb = 1; end
            MEMREAD:  begin adr = 1; end
            MEMWB:    begin rs = 1; rw = 1; end
            MEMWRITE: begin adr = 1; mw = 1; end
            EXECR:    begin asa = 2; aop = 2; end
            ALUWB:    begin rw = 1; end
            EXECI:    begin asa = 2; asb = 1; aop = 2; end
            JAL:      begin asa = 1; asb = 2; pcw = 1; end
            BEQ:      begin asa = 2; aop = 1; pcw = z; end
            default:  ;
        endcase
        return {pcw, irw, rw, mw, adr, rs, asa, asb, aop, imm, ill};
    endfunction

    // One clock cycle: drive inputs, check at the falling edge, advance past the rising edge.
    task automatic step(input int st, input int mr, input logic [6:0] iop, input logic zb,
                        input logic ill, input string tag);
        logic [6:0] o;
        logic z;
        o = (st == FETCH) ? 7'($urandom) : iop;
        z = (st == BEQ) ? zb : 1'($urandom);
        op = o;
        zero = z;
        mem_ready = 1'(mr);
        @(negedge clk);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_outs"}, 32'(w_out), 32'(exp_out(st, o, z, 1'(mr), ill)));
        if (MemWrite) memwrite_cycles++;
        @(posedge clk);
        #1;
    endtask

    task automatic push_wait(input int st, input int waits);
        for (int k = 0; k < waits; k++) begin
            q_st.push_back(st);
            q_mr.push_back(0);
        end
        q_st.push_back(st);
        q_mr.push_back(1);
    endtask

    task automatic push_one(input int st);
        q_st.push_back(st);
        q_mr.push_back(int'($urandom_range(1, 0)));
    endtask

    task automatic run_instr(input logic [6:0] iop, input int fw, input int mw,
                             input logic zb, input string tag);
        q_st.delete();
        q_mr.delete();
        push_wait(FETCH, fw);
        push_one(DECODE);
        case (iop)
            OP_LW:   begin push_one(MEMADR); push_wait(MEMREAD, mw); push_one(MEMWB); end
            OP_SW:   begin push_one(MEMADR); push_wait(MEMWRITE, mw); end
            OP_R:    begin push_one(EXECR); push_one(ALUWB); end
            OP_I:    begin push_one(EXECI); push_one(ALUWB); end
            OP_JAL:  begin push_one(JAL); push_one(ALUWB); end
            default: push_one(BEQ);
        endcase
        memwrite_cycles = 0;
        for (int i = 0; i < q_st.size(); i++) begin
            step(q_st[i], q_mr[i], iop, zb, 1'b0, tag);
        end
    endtask

    logic [6:0] ops[6];

    initial begin
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
        rst = 1'b1;
        op = 7'd0;
        zero = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_state", 32'(state), 32'(FETCH));
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(OP_LW, 0, 0, 1'b0, "lw");
        run_instr(OP_SW, 0, 2, 1'b0, "sw_wait");
        check("sw_memwrite_cycles", 32'(memwrite_cycles), 32'd3);
        run_instr(OP_BEQ, 0, 0, 1'b1, "beq_taken");
        run_instr(OP_BEQ, 0, 0, 1'b0, "beq_not");
        run_instr(OP_JAL, 0, 0, 1'b0, "jal");
        run_instr(OP_R, 3, 0, 1'b0, "fetch_wait");
        run_instr(OP_I, 0, 0, 1'b0, "itype");

        for (int n = 0; n < 200; n++) begin
            run_instr(ops[$urandom_range(5, 0)], int'($urandom_range(3, 0)),
                      int'($urandom_range(3, 0)), 1'($urandom), "rand");
        end

        // Reset arriving while a store is still waiting on memory.
        step(FETCH, 1, OP_SW, 1'b0, 1'b0, "rstmw");
        step(DECODE, 1, OP_SW, 1'b0, 1'b0, "rstmw");
        step(MEMADR, 1, OP_SW, 1'b0, 1'b0, "rstmw");
        mem_ready = 1'b0;
        @(negedge clk);
        check("rstmw_memwrite_pre", 32'(MemWrite), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmw_memwrite_forced", 32'(MemWrite), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmw_state", 32'(state), 32'(FETCH));
        run_instr(OP_LW, 1, 1, 1'b0, "after_rst");

        // Illegal opcode: trap must hold with all strobes low until reset.
        step(FETCH, 1, OP_BAD, 1'b0, 1'b0, "trap");
        step(DECODE, 1, OP_BAD, 1'b0, 1'b0, "trap");
        for (int t = 0; t < 10; t++) begin
            step(TRAP, int'($urandom_range(1, 0)), 7'($urandom), 1'b0, 1'b1, "trap");
        end
        rst = 1'b1;
        @(negedge clk);
        check("trap_rst_strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("trap_rst_state", 32'(state), 32'(FETCH));
        check("trap_rst_illegal", 32'(illegal), 32'd0);
        run_instr(OP_JAL, 0, 0, 1'b0, "post_trap");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
